// File: rtl/wbm_cmd_pkg.sv
// wbm_cmd_pkg: shared FSM state encoding, default timeout and data width for the command engine
package wbm_cmd_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;
  localparam int unsigned DATA_W = 16;
endpackage

// File: rtl/wbm_cmd_engine_if.sv
// wbm_cmd_engine_if: command/response handshake plus Wishbone classic master bus
//   cmd_*  : command offer (valid/ready, we, byte address, lane select, write data)
//   rsp_*  : response hold (valid/ready, read data, timeout flag)
//   wbm_*  : Wishbone master strobes, request fields, slave data and ack
//   modport master = engine view, modport slave = environment view
interface wbm_cmd_engine_if;
  import wbm_cmd_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [31:0]       cmd_adr;
  logic [1:0]        cmd_sel;
  logic [DATA_W-1:0] cmd_dat;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_timeout;
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [1:0]        wbm_sel_o;
  logic [31:0]       wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;
  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_timeout,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_timeout,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wbm_cmd_engine.sv
// wbm_cmd_engine: runs one Wishbone classic cycle per accepted command and holds the response
//   wb_clk_i : clock (rising edge)
//   wb_rst_i : asynchronous active-high reset
//   bus      : command, response and Wishbone master signals (master modport)
module wbm_cmd_engine
  import wbm_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wbm_cmd_engine_if.master bus
);
  state_t      state;
  logic [15:0] cnt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_dat     <= '0;
      bus.rsp_timeout <= 1'b0;
      bus.wbm_cyc_o   <= 1'b0;
      bus.wbm_stb_o   <= 1'b0;
      bus.wbm_we_o    <= 1'b0;
      bus.wbm_sel_o   <= '0;
      bus.wbm_adr_o   <= '0;
      bus.wbm_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is low only in the first IDLE cycle after reset
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            bus.wbm_we_o  <= bus.cmd_we;
            bus.wbm_adr_o <= bus.cmd_adr;
            bus.wbm_sel_o <= bus.cmd_sel;
            bus.wbm_dat_o <= bus.cmd_dat;
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            cnt           <= '0;
            state         <= BUS;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        BUS: begin
          // ack is tested first so it wins over a timeout in the same cycle
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.rsp_dat     <= bus.wbm_we_o ? '0 : bus.wbm_dat_i;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
              bus.wbm_cyc_o   <= 1'b0;
              bus.wbm_stb_o   <= 1'b0;
              bus.rsp_dat     <= '0;
              bus.rsp_timeout <= 1'b1;
              bus.rsp_valid   <= 1'b1;
              state           <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wbm_cmd_engine.sv
// tb_wbm_cmd_engine: randomized and directed checks of wbm_cmd_engine against a memory-based reference
module tb_wbm_cmd_engine;
  localparam int T8 = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] slv_mem [256];
  logic [15:0] ref_mem [256];
  wbm_cmd_engine_if b ();
  wbm_cmd_engine_if c ();
  wbm_cmd_engine #(.TIMEOUT_CYCLES(T8)) dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .bus(b.master));
  wbm_cmd_engine #(.TIMEOUT_CYCLES(4))  dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .bus(c.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] sel);
    return {sel[1] ? d[15:8] : old[15:8], sel[0] ? d[7:0] : old[7:0]};
  endfunction
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat, input int dly, input int hold, output logic [15:0] got);
    int n, k, stb_n, idx, exp_n;
    logic to;
    logic [15:0] exp_d;
    idx = (int'(adr) / 2) % 256;
    to = dly >= T8;
    exp_n = to ? T8 : dly + 1;
    exp_d = (to || we) ? 16'h0 : ref_mem[idx];
    if (!to && we) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
    b.cmd_we = we; b.cmd_adr = adr; b.cmd_sel = sel; b.cmd_dat = dat; b.cmd_valid = 1'b1;
    n = 0;
    while (!b.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept", 32'(n < 20), 32'd1);
    @(negedge clk);
    b.cmd_valid = 1'b0; b.cmd_we = ~we; b.cmd_adr = $urandom; b.cmd_sel = ~sel; b.cmd_dat = 16'($urandom);
    chk("busy_ready", 32'(b.cmd_ready), 32'd0);
    k = 0; stb_n = 0;
    while (!b.rsp_valid && k < T8 + 5) begin
      if (b.wbm_cyc_o && b.wbm_stb_o) stb_n++;
      chk("we_o", 32'(b.wbm_we_o), 32'(we));
      chk("adr_o", b.wbm_adr_o, adr);
      chk("sel_o", 32'(b.wbm_sel_o), 32'(sel));
      chk("dat_o", 32'(b.wbm_dat_o), 32'(dat));
      b.wbm_dat_i = slv_mem[b.wbm_adr_o[8:1]];
      b.wbm_ack_i = (k == dly);
      if (k == dly && b.wbm_cyc_o && b.wbm_stb_o && b.wbm_we_o)
        slv_mem[b.wbm_adr_o[8:1]] = merge(slv_mem[b.wbm_adr_o[8:1]], b.wbm_dat_o, b.wbm_sel_o);
      @(negedge clk);
      b.wbm_ack_i = 1'b0; b.wbm_dat_i = 16'($urandom);
      k++;
    end
    chk("stb_cycles", 32'(stb_n), 32'(exp_n));
    chk("latency", 32'(k), 32'(exp_n));
    chk("cyc_drop", 32'(b.wbm_cyc_o), 32'd0);
    chk("rsp_valid", 32'(b.rsp_valid), 32'd1);
    chk("rsp_timeout", 32'(b.rsp_timeout), 32'(to));
    chk("rsp_dat", 32'(b.rsp_dat), 32'(exp_d));
    got = b.rsp_dat;
    for (int h = 0; h < hold; h++) begin
      b.wbm_ack_i = to && h == 3;
      b.wbm_dat_i = 16'hDEAD;
      @(negedge clk);
      b.wbm_ack_i = 1'b0;
      chk("hold_valid", 32'(b.rsp_valid), 32'd1);
      chk("hold_dat", 32'(b.rsp_dat), 32'(exp_d));
      chk("hold_to", 32'(b.rsp_timeout), 32'(to));
      chk("hold_ready", 32'(b.cmd_ready), 32'd0);
      chk("hold_cyc", 32'(b.wbm_cyc_o), 32'd0);
    end
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
    chk("rsp_release", 32'(b.rsp_valid), 32'd0);
    chk("ready_back", 32'(b.cmd_ready), 32'd1);
  endtask
  initial begin
    logic [15:0] got;
    int n, k, stb_n;
    for (int i = 0; i < 256; i++) begin slv_mem[i] = 16'($urandom); ref_mem[i] = slv_mem[i]; end
    b.cmd_valid = 0; b.cmd_we = 0; b.cmd_adr = 0; b.cmd_sel = 0; b.cmd_dat = 0;
    b.rsp_ready = 0; b.wbm_dat_i = 0; b.wbm_ack_i = 0;
    c.cmd_valid = 0; c.cmd_we = 0; c.cmd_adr = 0; c.cmd_sel = 0; c.cmd_dat = 0;
    c.rsp_ready = 0; c.wbm_dat_i = 0; c.wbm_ack_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(b.cmd_ready), 32'd0);
    chk("rst_valid", 32'(b.rsp_valid), 32'd0);
    chk("rst_dat", 32'(b.rsp_dat), 32'd0);
    chk("rst_to", 32'(b.rsp_timeout), 32'd0);
    chk("rst_wbm", {26'd0, b.wbm_cyc_o, b.wbm_stb_o, b.wbm_we_o, b.wbm_sel_o, 1'b0}, 32'd0);
    chk("rst_adr", b.wbm_adr_o, 32'd0);
    chk("rst_dat_o", 32'(b.wbm_dat_o), 32'd0);
    rst = 1'b0;
    chk("ready_pre_edge", 32'(b.cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_post_edge", 32'(b.cmd_ready), 32'd1);
    run_cmd(1'b1, 32'h22, 2'b11, 16'hA5C3, 1, 0, got);
    run_cmd(1'b0, 32'h22, 2'b11, 16'h0000, 1, 0, got);
    chk("read_a5c3", 32'(got), 32'h0000A5C3);
    run_cmd(1'b1, 32'h40, 2'b11, 16'hFFFF, 1, 0, got);
    run_cmd(1'b1, 32'h40, 2'b01, 16'h1234, 1, 0, got);
    run_cmd(0, 32'h40, 2'b11, 16'h0000, 0, 0, got);
    chk("read_ff34", 32'(got), 32'h0000FF34);
    run_cmd(1'b0, 32'h44, 2'b11, 16'h0000, 1000, 6, got);
    chk("timeout_dat", 32'(got), 32'd0);
    run_cmd(1'b1, 32'h50, 2'b11, 16'hBEEF, 2, 0, got);
    run_cmd(1'b0, 32'h50, 2'b11, 16'h0000, 1, 20, got);
    chk("read_beef", 32'(got), 32'h0000BEEF);
    run_cmd(1'b0, 32'h22, 2'b11, 16'h0000, T8 - 1, 1, got);
    chk("coincide8", 32'(got), 32'h0000A5C3);
    c.cmd_we = 0; c.cmd_adr = 32'h10; c.cmd_sel = 2'b11; c.cmd_valid = 1'b1;
    n = 0;
    while (!c.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("c_accept", 32'(n < 20), 32'd1);
    @(negedge clk);
    c.cmd_valid = 1'b0;
    k = 0; stb_n = 0;
    while (!c.rsp_valid && k < 10) begin
      if (c.wbm_stb_o) stb_n++;
      c.wbm_dat_i = 16'h0F0F;
      c.wbm_ack_i = (k == 3);
      @(negedge clk);
      c.wbm_ack_i = 1'b0;
      k++;
    end
    chk("c_stb_cycles", 32'(stb_n), 32'd4);
    chk("c_valid", 32'(c.rsp_valid), 32'd1);
    chk("c_timeout", 32'(c.rsp_timeout), 32'd0);
    chk("c_dat", 32'(c.rsp_dat), 32'h00000F0F);
    c.rsp_ready = 1'b1;
    @(negedge clk);
    c.rsp_ready = 1'b0;
    chk("c_release", 32'(c.rsp_valid), 32'd0);
    b.cmd_we = 1'b1; b.cmd_adr = 32'h60; b.cmd_sel = 2'b11; b.cmd_dat = 16'h7777; b.cmd_valid = 1'b1;
    n = 0;
    while (!b.cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    b.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_cyc_pre", 32'(b.wbm_cyc_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc", 32'(b.wbm_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(b.wbm_stb_o), 32'd0);
    chk("rst_mid_valid", 32'(b.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid2", 32'(b.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rst_mid_ready", 32'(b.cmd_ready), 32'd1);
    chk("rst_mid_novalid", 32'(b.rsp_valid), 32'd0);
    run_cmd(1'b0, 32'h60, 2'b11, 16'h0000, 1, 0, got);
    for (int t = 0; t < 40; t++) begin
      int dly;
      logic we;
      dly = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      run_cmd(we, 32'($urandom_range(0, 15) * 2), 2'($urandom_range(0, 3)), 16'($urandom),
              dly, dly >= T8 ? 5 : $urandom_range(0, 3), got);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
